ro_puf_eval_ctrl: RTL and testbench

- Sequencer for the ring-oscillator PUF datapath. Generates one NUM_BITS-bit response per start request.
- For each response bit it selects an oscillator pair through the two mux selects, clears both ripple counters, enables the oscillators for a fixed window, then waits for the counters to settle.
- It then samples both counts and records a comparison bit.
- It sits between the challenge/response I/O logic and the oscillator/mux/counter arrays.

---
 rtl/ro_puf_eval_ctrl_if.sv | 39 +++
 rtl/ro_puf_eval_ctrl.sv | 153 +++++++++++++++
 tb/tb_ro_puf_eval_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ro_puf_eval_ctrl_if.sv
// rtl/ro_puf_eval_ctrl_if.sv - signal bundle between the RO-PUF sequencer and its surroundings
// master: the sequencer (drives oscillator controls, selects and results).
// slave : challenge/response logic plus oscillator/mux/counter arrays.
//   start, abort, challenge : evaluation request, cancel, base oscillator index
//   ro_en, cnt_clr          : oscillator enable, ripple counter clear strobe
//   sel_a, sel_b            : oscillator pair mux selects
//   count_a, count_b        : ripple counter values
//   busy, done              : evaluation in progress, one-cycle completion pulse
//   response, tie_cnt       : response word, equal-count comparisons (saturating)
//   sat_flag                : a counter reached all-ones during the evaluation
interface ro_puf_eval_ctrl_if #(
    parameter int CNT_W    = 8,
    parameter int NUM_BITS = 8
);
    logic                start;
    logic                abort;
    logic [4:0]          challenge;
    logic                ro_en;
    logic                cnt_clr;
    logic [4:0]          sel_a;
    logic [4:0]          sel_b;
    logic [CNT_W-1:0]    count_a;
    logic [CNT_W-1:0]    count_b;
    logic                busy;
    logic                done;
    logic [NUM_BITS-1:0] response;
    logic [4:0]          tie_cnt;
    logic                sat_flag;

    modport master (
        input  start, abort, challenge, count_a, count_b,
        output ro_en, cnt_clr, sel_a, sel_b, busy, done, response, tie_cnt, sat_flag
    );

    modport slave (
        output start, abort, challenge, count_a, count_b,
        input  ro_en, cnt_clr, sel_a, sel_b, busy, done, response, tie_cnt, sat_flag
    );
endinterface

// File: rtl/ro_puf_eval_ctrl.sv
// rtl/ro_puf_eval_ctrl.sv - ring-oscillator PUF evaluation sequencer
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : ro_puf_eval_ctrl_if.master (request, oscillator control, counts, results)
// Per response bit: CLEAR (1) -> RUN (WINDOW) -> SETTLE (SETTLE) -> SAMPLE (1).
module ro_puf_eval_ctrl #(
    parameter int WINDOW   = 16,
    parameter int SETTLE   = 4,
    parameter int CNT_W    = 8,
    parameter int NUM_BITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    ro_puf_eval_ctrl_if.master bus
);
    localparam int KW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t              state;
    logic [15:0]         tmr;
    logic [KW-1:0]       k;
    logic [4:0]          base;
    logic                ro_en_q;
    logic                cnt_clr_q;
    logic [4:0]          sel_a_q;
    logic [4:0]          sel_b_q;
    logic                busy_q;
    logic                done_q;
    logic [NUM_BITS-1:0] response_q;
    logic [4:0]          tie_cnt_q;
    logic                sat_flag_q;

    logic [KW-1:0]       k_nxt;
    logic [4:0]          nxt_off;
    logic                cnt_tie;
    logic                cnt_sat;

    assign k_nxt   = k + KW'(1);
    // Pair for the next bit starts at base + 2*(k+1); 5-bit arithmetic wraps mod 32.
    assign nxt_off = 5'({k_nxt, 1'b0});
    assign cnt_tie = (bus.count_a == bus.count_b);
    assign cnt_sat = (bus.count_a == '1) || (bus.count_b == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            tmr        <= '0;
            k          <= '0;
            base       <= '0;
            ro_en_q    <= 1'b0;
            cnt_clr_q  <= 1'b0;
            sel_a_q    <= '0;
            sel_b_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            response_q <= '0;
            tie_cnt_q  <= '0;
            sat_flag_q <= 1'b0;
        end else if (state != ST_IDLE && bus.abort) begin
            // Abort wins over every normal transition; partial response is kept.
            state     <= ST_IDLE;
            ro_en_q   <= 1'b0;
            cnt_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        base       <= bus.challenge;
                        k          <= '0;
                        response_q <= '0;
                        tie_cnt_q  <= '0;
                        sat_flag_q <= 1'b0;
                        sel_a_q    <= bus.challenge;
                        sel_b_q    <= bus.challenge + 5'd1;
                        cnt_clr_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    cnt_clr_q <= 1'b0;
                    ro_en_q   <= 1'b1;
                    tmr       <= 16'(WINDOW - 1);
                    state     <= ST_RUN;
                end
                ST_RUN: begin
                    if (tmr == '0) begin
                        ro_en_q <= 1'b0;
                        tmr     <= 16'(SETTLE - 1);
                        state   <= ST_SETTLE;
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end
                ST_SETTLE: begin
                    if (tmr == '0) begin
                        state <= ST_SAMPLE;
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end
                ST_SAMPLE: begin
                    response_q[k] <= (bus.count_a > bus.count_b);
                    if (cnt_tie && tie_cnt_q != 5'd31) begin
                        tie_cnt_q <= tie_cnt_q + 5'd1;
                    end
                    if (cnt_sat) begin
                        sat_flag_q <= 1'b1;
                    end
                    if (k == KW'(NUM_BITS - 1)) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        k         <= k_nxt;
                        sel_a_q   <= base + nxt_off;
                        sel_b_q   <= base + nxt_off + 5'd1;
                        cnt_clr_q <= 1'b1;
                        state     <= ST_CLEAR;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ro_en    = ro_en_q;
    assign bus.cnt_clr  = cnt_clr_q;
    assign bus.sel_a    = sel_a_q;
    assign bus.sel_b    = sel_b_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.response = response_q;
    assign bus.tie_cnt  = tie_cnt_q;
    assign bus.sat_flag = sat_flag_q;
endmodule

// File: tb/tb_ro_puf_eval_ctrl.sv
// tb/tb_ro_puf_eval_ctrl.sv - scoreboard bench for ro_puf_eval_ctrl
module tb_ro_puf_eval_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ro_puf_eval_ctrl_if #(.CNT_W(8), .NUM_BITS(8)) bus ();

    ro_puf_eval_ctrl #(.WINDOW(16), .SETTLE(4), .CNT_W(8), .NUM_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] resp;
        logic [4:0] tie;
        logic       sat;
        logic       busy;
        int         lat;
        int         rises;
    } rec_t;

    rec_t       done_q[$];
    rec_t       exp_q[$];
    logic [9:0] sel_q[$];
    int         acc_q[$];
    int         tests = 0;
    int         fails = 0;
    int         acc_cyc = 0;
    int         rises = 0;
    int         overlap = 0;
    logic       prev_busy = 1'b0;
    logic       prev_ro = 1'b0;
    int         mode_r = 0;
    logic [4:0] cur_base = 5'd0;

    // Counter model: count pair depends on which bit the selects point at.
    function automatic logic [15:0] counts(int mode, int k);
        case (mode)
            0:       return (k % 2 == 0) ? {8'd200, 8'd100} : {8'd50, 8'd90};
            1:       return {8'd255, 8'd255};
            default: begin
                case (k % 3)
                    0:       return {8'd77, 8'd77};
                    1:       return {8'd100, 8'd50};
                    default: return {8'd20, 8'd30};
                endcase
            end
        endcase
    endfunction

    wire [4:0] kd = bus.sel_a - cur_base;
    assign {bus.count_a, bus.count_b} = counts(mode_r, int'(kd[4:1]));

    always @(negedge clk) begin
        if (bus.busy === 1'b1 && prev_busy !== 1'b1) begin
            acc_cyc = cyc - 1;
            rises   = 0;
            acc_q.push_back(acc_cyc);
        end
        if (bus.ro_en === 1'b1 && prev_ro !== 1'b1) rises++;
        if (bus.cnt_clr === 1'b1) sel_q.push_back({bus.sel_a, bus.sel_b});
        if (bus.ro_en === 1'b1 && bus.cnt_clr === 1'b1) overlap++;
        if (bus.done === 1'b1) begin
            rec_t r;
            r.resp  = bus.response;
            r.tie   = bus.tie_cnt;
            r.sat   = bus.sat_flag;
            r.busy  = bus.busy;
            r.lat   = cyc - acc_cyc;
            r.rises = rises;
            done_q.push_back(r);
        end
        prev_busy = bus.busy;
        prev_ro   = bus.ro_en;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t model(int mode);
        rec_t r;
        r.resp = '0; r.tie = '0; r.sat = 1'b0; r.busy = 1'b0; r.lat = 177; r.rises = 8;
        for (int k = 0; k < 8; k++) begin
            logic [15:0] c;
            c = counts(mode, k);
            r.resp[k] = (c[15:8] > c[7:0]);
            if (c[15:8] == c[7:0] && r.tie != 5'd31) r.tie = r.tie + 5'd1;
            if (c[15:8] == 8'hff || c[7:0] == 8'hff) r.sat = 1'b1;
        end
        return r;
    endfunction

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_q.size() == 0 && n < 600) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_q.size() != 0), 32'd1);
    endtask

    task automatic compare_done(input string tag);
        rec_t g, e;
        if (done_q.size() > 0 && exp_q.size() > 0) begin
            g = done_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_response"}, 32'(g.resp), 32'(e.resp));
            chk({tag, "_tie_cnt"},  32'(g.tie),  32'(e.tie));
            chk({tag, "_sat_flag"}, 32'(g.sat),  32'(e.sat));
            chk({tag, "_busy_at_done"}, 32'(g.busy), 32'(e.busy));
            chk({tag, "_done_latency"}, 32'(g.lat), 32'(e.lat));
            chk({tag, "_ro_en_rises"}, 32'(g.rises), 32'(e.rises));
        end
    endtask

    task automatic check_sels(input string tag, input logic [4:0] b);
        for (int k = 0; k < 8; k++) begin
            logic [9:0] got;
            logic [4:0] ea, eb;
            ea  = b + 5'(2 * k);
            eb  = ea + 5'd1;
            got = (sel_q.size() > 0) ? sel_q.pop_front() : 10'bx;
            chk($sformatf("%s_sel_pair%0d", tag, k), 32'(got), 32'({ea, eb}));
        end
    endtask

    task automatic run_eval(input string tag, input logic [4:0] b, input int mode);
        cur_base = b;
        mode_r   = mode;
        exp_q.push_back(model(mode));
        sel_q.delete();
        bus.challenge = b;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.challenge = 5'($urandom_range(0, 31));
        wait_done(tag);
        compare_done(tag);
        check_sels(tag, b);
        repeat (3) tick();
    endtask

    task automatic wait_rises(input int n);
        int t = 0;
        while (rises < n && t < 400) begin
            tick();
            t++;
        end
        chk($sformatf("reach_ro_en_rise%0d", n), 32'(rises >= n), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ro_en"},    32'(bus.ro_en),    32'd0);
        chk({tag, "_cnt_clr"},  32'(bus.cnt_clr),  32'd0);
        chk({tag, "_busy"},     32'(bus.busy),     32'd0);
        chk({tag, "_done"},     32'(bus.done),     32'd0);
        chk({tag, "_response"}, 32'(bus.response), 32'd0);
        chk({tag, "_tie_cnt"},  32'(bus.tie_cnt),  32'd0);
        chk({tag, "_sat_flag"}, 32'(bus.sat_flag), 32'd0);
        chk({tag, "_sel_a"},    32'(bus.sel_a),    32'd0);
        chk({tag, "_sel_b"},    32'(bus.sel_b),    32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b1;
        bus.abort     = 1'b0;
        bus.challenge = 5'd7;
        repeat (3) tick();
        check_all_zero("reset_with_start");
        reset     = 1'b0;
        bus.start = 1'b0;
        tick();
        chk("idle_after_reset_busy", 32'(bus.busy), 32'd0);

        run_eval("nominal", 5'd4, 0);
        run_eval("ties_sat", 5'd9, 1);
        run_eval("wrap", 5'd30, 2);

        // Abort in the 3rd RUN cycle of bit 2.
        cur_base = 5'd4;
        mode_r   = 0;
        sel_q.delete();
        bus.challenge = 5'd4;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_rises(3);
        tick();
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_busy",     32'(bus.busy),     32'd0);
        chk("abort_ro_en",    32'(bus.ro_en),    32'd0);
        chk("abort_cnt_clr",  32'(bus.cnt_clr),  32'd0);
        chk("abort_response", 32'(bus.response), 32'h01);
        repeat (30) tick();
        chk("abort_no_done", 32'(done_q.size()), 32'd0);
        chk("abort_stays_idle", 32'(bus.busy), 32'd0);
        bus.abort = 1'b1;
        repeat (2) tick();
        bus.abort = 1'b0;
        chk("abort_in_idle_resp", 32'(bus.response), 32'h01);

        // Reset during SETTLE of bit 5.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_rises(6);
        repeat (17) tick();
        chk("mid_settle_ro_en", 32'(bus.ro_en), 32'd0);
        chk("mid_partial_resp", 32'(bus.response), 32'h15);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("reset_mid_op");
        repeat (2) tick();
        chk("reset_mid_no_done", 32'(done_q.size()), 32'd0);

        // Start held high continuously.
        sel_q.delete();
        acc_q.delete();
        exp_q.push_back(model(0));
        exp_q.push_back(model(0));
        bus.challenge = 5'd4;
        bus.start     = 1'b1;
        repeat (300) tick();
        bus.start = 1'b0;
        wait_done("held1");
        compare_done("held1");
        wait_done("held2");
        compare_done("held2");
        check_sels("held1", 5'd4);
        check_sels("held2", 5'd4);
        chk("held_accept_count", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() >= 2) chk("held_accept_gap", 32'(acc_q[1] - acc_q[0]), 32'd178);
        repeat (5) tick();
        chk("held_idle_busy", 32'(bus.busy), 32'd0);
        chk("ro_en_cnt_clr_overlap", 32'(overlap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
